// File: rtl/pu_driver_pkg.sv
// Shared types and constants for the PU feeding sequencer.
package pu_driver_pkg;

  localparam int FP_WIDTH  = 32;
  localparam int ROW_WORDS = 4;
  localparam int ROW_WIDTH = ROW_WORDS * FP_WIDTH;

  localparam logic [FP_WIDTH-1:0] FP_POS_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_WRITE,
    ST_CAPTURE,
    ST_EMIT
  } state_t;

  // Word k of a weight row; word 0 sits in the least significant bits.
  function automatic logic [FP_WIDTH-1:0] row_word(input logic [ROW_WIDTH-1:0] row,
                                                  input int k);
    return row[k*FP_WIDTH +: FP_WIDTH];
  endfunction

endpackage

// File: rtl/pu_driver_fp.sv
// fp_relu: clamps any value with the sign bit set (negatives, -0.0, negative
// NaNs) to +0.0. Pure wiring on the sign bit, no FP arithmetic.
module fp_relu
  import pu_driver_pkg::*;
(
  input  logic [FP_WIDTH-1:0] a,
  output logic [FP_WIDTH-1:0] y
);

  assign y = a[FP_WIDTH-1] ? FP_POS_ZERO : a;

endmodule

// File: rtl/pu_driver.sv
// pu_driver: walks N_NEURONS weight rows, feeds x/w to the PU, pulses
// mult_write, captures the PU sum and streams each neuron result out.
// Optional feature macro: PU_DRIVER_RELU_EN (ReLU on captured results).
//
// state   | meaning
// IDLE    | waiting for start; x_in latched on accepted start
// FETCH   | w_rd asserted for row idx
// LOAD    | memory data valid, w1..w4 loaded
// WRITE   | mult_write pulse, PU captures x/w
// CAPTURE | PU sum (optionally ReLU'd) registered with idx
// EMIT    | result_valid held until handshake
module pu_driver
  import pu_driver_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int ADDR_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [FP_WIDTH-1:0]  x_in1,
  input  logic [FP_WIDTH-1:0]  x_in2,
  input  logic [FP_WIDTH-1:0]  x_in3,
  input  logic [FP_WIDTH-1:0]  x_in4,
  output logic                 busy,
  output logic                 done,
  output logic                 w_rd,
  output logic [ADDR_W-1:0]    w_addr,
  input  logic [ROW_WIDTH-1:0] w_data,
  output logic [FP_WIDTH-1:0]  x1,
  output logic [FP_WIDTH-1:0]  x2,
  output logic [FP_WIDTH-1:0]  x3,
  output logic [FP_WIDTH-1:0]  x4,
  output logic [FP_WIDTH-1:0]  w1,
  output logic [FP_WIDTH-1:0]  w2,
  output logic [FP_WIDTH-1:0]  w3,
  output logic [FP_WIDTH-1:0]  w4,
  output logic                 mult_write,
  input  logic [FP_WIDTH-1:0]  a,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [FP_WIDTH-1:0]  result_data,
  output logic [ADDR_W-1:0]    result_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURONS - 1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   idx;
  logic [FP_WIDTH-1:0] a_f;
  logic                handshake;
  logic                last_row;

  assign handshake = result_valid & result_ready;
  assign last_row  = (idx == LAST_IDX);
  assign w_addr    = idx;

`ifdef PU_DRIVER_RELU_EN
  fp_relu u_relu (
    .a (a),
    .y (a_f)
  );
`else
  assign a_f = a;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and strobe decode; strobes are pure state decodes so they
  // drop to 0 together with the state on reset.
  always_comb begin
    state_nxt    = state;
    busy         = 1'b1;
    w_rd         = 1'b0;
    mult_write   = 1'b0;
    result_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_rd      = 1'b1;
        state_nxt = ST_LOAD;
      end
      ST_LOAD:    state_nxt = ST_WRITE;
      ST_WRITE: begin
        mult_write = 1'b1;
        state_nxt  = ST_CAPTURE;
      end
      ST_CAPTURE: state_nxt = ST_EMIT;
      ST_EMIT: begin
        result_valid = 1'b1;
        if (handshake) state_nxt = last_row ? ST_IDLE : ST_FETCH;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: operands, result, neuron index and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      x1          <= '0;
      x2          <= '0;
      x3          <= '0;
      x4          <= '0;
      w1          <= '0;
      w2          <= '0;
      w3          <= '0;
      w4          <= '0;
      result_data <= '0;
      result_idx  <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            x1  <= x_in1;
            x2  <= x_in2;
            x3  <= x_in3;
            x4  <= x_in4;
            idx <= '0;
          end
        end
        ST_LOAD: begin
          w1 <= row_word(w_data, 0);
          w2 <= row_word(w_data, 1);
          w3 <= row_word(w_data, 2);
          w4 <= row_word(w_data, 3);
        end
        ST_CAPTURE: begin
          result_data <= a_f;
          result_idx  <= idx;
        end
        ST_EMIT: begin
          if (handshake) begin
            if (last_row) done <= 1'b1;
            else          idx  <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_driver.sv
// Testbench for pu_driver: table-driven runs, hand-written corner sequences
// and randomized runs checked against a dot-product reference model.
module tb_pu_driver;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  x_in1, x_in2, x_in3, x_in4;
  logic         busy, done, w_rd, mult_write, result_valid, result_ready;
  logic [1:0]   w_addr, result_idx;
  logic [127:0] w_data;
  logic [31:0]  x1, x2, x3, x4, w1, w2, w3, w4, a, result_data;

  pu_driver #(.N_NEURONS(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_in1(x_in1), .x_in2(x_in2), .x_in3(x_in3), .x_in4(x_in4),
    .busy(busy), .done(done), .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4), .w1(w1), .w2(w2), .w3(w3), .w4(w4),
    .mult_write(mult_write), .a(a), .result_valid(result_valid),
    .result_ready(result_ready), .result_data(result_data), .result_idx(result_idx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] xv[4];
  logic [31:0] wv[4][4];
  logic [31:0] ev[4];

  // Single <-> double conversion, exact for zeros and normal numbers.
  function automatic real sp2real(input logic [31:0] b);
    logic [10:0] e;
    if (b[30:0] == 31'd0) return $bitstoreal({b[31], 63'd0});
    e = 11'(b[30:23]) + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] post_f(input logic [31:0] v);
`ifdef PU_DRIVER_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  // Environment: synchronous weight memory and a PU with x/w registers.
  always @(posedge clk) if (w_rd) w_data <= {wv[w_addr][3], wv[w_addr][2], wv[w_addr][1], wv[w_addr][0]};

  logic [31:0] px[4], pw[4];
  initial begin
    for (int i = 0; i < 4; i++) begin px[i] = 32'h0; pw[i] = 32'h0; end
    w_data = '0;
  end
  always @(posedge clk) if (mult_write) begin
    px[0] <= x1; px[1] <= x2; px[2] <= x3; px[3] <= x4;
    pw[0] <= w1; pw[1] <= w2; pw[2] <= w3; pw[3] <= w4;
  end
  always_comb begin
    a = real2sp(((sp2real(px[0]) * sp2real(pw[0]) + sp2real(px[1]) * sp2real(pw[1]))
                 + sp2real(px[2]) * sp2real(pw[2])) + sp2real(px[3]) * sp2real(pw[3]));
  end

  // Reference: neuron i result is f(sum_j x_j * w_ij).
  function automatic logic [31:0] ref_neuron(input int i);
    real s;
    s = sp2real(xv[0]) * sp2real(wv[i][0]);
    for (int j = 1; j < 4; j++) s = s + sp2real(xv[j]) * sp2real(wv[i][j]);
    return post_f(real2sp(s));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic all_zero();
    return ({busy, done, w_rd, w_addr, x1, x2, x3, x4, w1, w2, w3, w4,
             mult_write, result_valid, result_data, result_idx} == '0);
  endfunction

  // mode 0: ready=1 with timing checks; 1: stall 3 cycles at idx 1;
  // 2: random ready; 3: ready=1 and a stray start during LOAD of idx 2.
  task automatic do_run(input int mode);
    int cyc, got, stall, inj;
    logic bp, seen_valid;
    logic [31:0] p_data, p_w1, p_x1;
    logic [1:0] p_idx;
    x_in1 = xv[0]; x_in2 = xv[1]; x_in3 = xv[2]; x_in4 = xv[3];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; got = 0; stall = 0; inj = 0; bp = 1'b0; seen_valid = 1'b0;
    p_data = '0; p_w1 = '0; p_x1 = '0; p_idx = '0;
    while (got < 4 && cyc < 400) begin
      if (cyc == 1) begin
        chk("first_w_rd", {31'd0, w_rd}, 32'd1);
        chk("first_w_addr", {30'd0, w_addr}, 32'd0);
      end
      if (mode == 0 && cyc == 3) chk("mult_write_cycle3", {31'd0, mult_write}, 32'd1);
      if (mode == 0 && result_valid && !seen_valid) chk("first_valid_cycle", cyc, 32'd5);
      if (result_valid) seen_valid = 1'b1;
      chk("no_early_done", {31'd0, done}, 32'd0);
      if (bp) begin
        chk("bp_data_stable", result_data, p_data);
        chk("bp_idx_stable", {30'd0, result_idx}, {30'd0, p_idx});
        chk("bp_w1_stable", w1, p_w1);
        chk("bp_valid_held", {31'd0, result_valid}, 32'd1);
        chk("bp_no_strobes", {30'd0, w_rd, mult_write}, 32'd0);
      end
      if (inj == 2) begin start = 1'b0; inj = 3; end
      if (inj == 1) begin
        start = 1'b1; x_in1 = ~xv[0]; x_in2 = ~xv[1]; x_in3 = ~xv[2]; x_in4 = ~xv[3];
        inj = 2;
      end
      if (mode == 3 && inj == 0 && w_rd && w_addr == 2'd2) inj = 1;
      case (mode)
        1: if (result_valid && result_idx == 2'd1 && stall < 3) begin
             result_ready = 1'b0; stall++;
           end else result_ready = 1'b1;
        2: result_ready = 1'($urandom_range(0, 1));
        default: result_ready = 1'b1;
      endcase
      if (result_valid) begin
        chk("x_const", {x1 ^ xv[0]} | {x2 ^ xv[1]} | {x3 ^ xv[2]} | {x4 ^ xv[3]}, 32'd0);
        if (result_ready) begin
          chk($sformatf("result_data[%0d]", got), result_data, ev[got]);
          chk($sformatf("result_idx[%0d]", got), {30'd0, result_idx}, got);
          got++;
        end
      end
      bp = result_valid && !result_ready;
      p_data = result_data; p_idx = result_idx; p_w1 = w1; p_x1 = x1;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (got < 4) chk("run_timeout_results", got, 32'd4);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_busy_low", {31'd0, busy}, 32'd0);
    if (mode == 0) chk("done_cycle", cyc, 32'd21);
  endtask

  typedef struct {
    logic [31:0] x[4];
    logic [31:0] w[4][4];
    logic [31:0] e[4];
  } vec_t;

  vec_t tbl[2];
  logic [31:0] pool[6];

  task automatic load_vec(input int k);
    for (int i = 0; i < 4; i++) begin
      xv[i] = tbl[k].x[i];
      ev[i] = tbl[k].e[i];
      for (int j = 0; j < 4; j++) wv[i][j] = tbl[k].w[i][j];
    end
  endtask

  initial begin
    int budget;
    // basic run
    for (int j = 0; j < 4; j++) begin
      tbl[0].x[j] = 32'h3F80_0000;
      tbl[0].w[0][j] = 32'h3F80_0000;
      tbl[0].w[1][j] = 32'h4000_0000;
      tbl[0].w[2][j] = 32'h3F00_0000;
      tbl[0].w[3][j] = 32'h0000_0000;
    end
    tbl[0].e[0] = 32'h4080_0000; tbl[0].e[1] = 32'h4100_0000;
    tbl[0].e[2] = 32'h4000_0000; tbl[0].e[3] = 32'h0000_0000;
    // negative sums
    for (int i = 0; i < 4; i++) begin
      tbl[1].x[i] = 32'h3F80_0000;
      for (int j = 0; j < 4; j++) tbl[1].w[i][j] = 32'hBF80_0000;
`ifdef PU_DRIVER_RELU_EN
      tbl[1].e[i] = 32'h0000_0000;
`else
      tbl[1].e[i] = 32'hC080_0000;
`endif
    end
    pool[0] = 32'h3F80_0000; pool[1] = 32'h4000_0000; pool[2] = 32'h3F00_0000;
    pool[3] = 32'h0000_0000; pool[4] = 32'hBF80_0000; pool[5] = 32'hC000_0000;

    rst = 1'b1; start = 1'b0; result_ready = 1'b1;
    x_in1 = 32'hDEAD_BEEF; x_in2 = 32'h1234_5678; x_in3 = 32'hFFFF_FFFF; x_in4 = 32'h5555_AAAA;
    load_vec(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero", {31'd0, all_zero()}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 2; k++) begin
      load_vec(k);
      do_run(0);
    end

    // Back-to-back is exercised above; backpressure at idx 1.
    load_vec(0);
    do_run(1);

    // Stray start during LOAD of idx 2 must be ignored.
    load_vec(0);
    do_run(3);

    // Reset during WRITE of idx 1, then rerun from scratch.
    load_vec(0);
    x_in1 = xv[0]; x_in2 = xv[1]; x_in3 = xv[2]; x_in4 = xv[3];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    budget = 0;
    while (!(mult_write && w_addr == 2'd1) && budget < 100) begin
      @(posedge clk); #1; budget++;
    end
    chk("reach_write_idx1", {31'd0, mult_write}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrun_reset_zero", {31'd0, all_zero()}, 32'd1);
    rst = 1'b0;
    do_run(0);

    // Randomized runs against the reference model.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) begin
        xv[i] = pool[$urandom_range(0, 5)];
        for (int j = 0; j < 4; j++) wv[i][j] = pool[$urandom_range(0, 5)];
      end
      for (int i = 0; i < 4; i++) ev[i] = ref_neuron(i);
      do_run(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
